// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the two selector sources and the arbiter.
interface mux_sel_arbiter_if #(
  parameter int unsigned HOLD_W = 4
);
  logic              req_a;
  logic              req_b;
  logic [HOLD_W-1:0] hold_len;
  logic              sel;
  logic              grant_a;
  logic              grant_b;
  logic              busy;
  logic              switch_pulse;

  // Requester side: raises requests and programs the hold length.
  modport master (
    output req_a, req_b, hold_len,
    input  sel, grant_a, grant_b, busy, switch_pulse
  );

  // Arbiter side.
  modport slave (
    input  req_a, req_b, hold_len,
    output sel, grant_a, grant_b, busy, switch_pulse
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2:1 selector's sel line. Each grant lasts up to a
// programmable number of cycles; sel only moves when a grant to the other source starts.
module mux_sel_arbiter #(
  parameter int unsigned HOLD_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_sel_arbiter_if.slave      arb
);

  typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;

  localparam logic [HOLD_W-1:0] HoldOne = {{(HOLD_W-1){1'b0}}, 1'b1};

  state_e            r_state, w_state_d;
  logic [HOLD_W-1:0] r_cnt, w_cnt_d;
  logic [HOLD_W-1:0] r_hold, w_hold_d;
  logic              r_last, w_last_d;   // 0 = A served last, 1 = B
  logic              r_sel, w_sel_d;
  logic              r_pulse, w_pulse_d;
  logic              r_busy, w_busy_d;

  logic              w_enter;            // a grant starts (or restarts) on this edge
  logic              w_enter_b;          // the starting grant is for B
  logic              w_expired;

  assign w_expired = (r_cnt == (r_hold - HoldOne));

  // Next-state: arbitration, hold counting and grant-entry bookkeeping.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_hold_d  = r_hold;
    w_last_d  = r_last;
    w_sel_d   = r_sel;
    w_pulse_d = 1'b0;
    w_enter   = 1'b0;
    w_enter_b = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (arb.req_a && arb.req_b) begin
          w_enter   = 1'b1;
          w_enter_b = ~r_last;
        end else if (arb.req_a) begin
          w_enter   = 1'b1;
          w_enter_b = 1'b0;
        end else if (arb.req_b) begin
          w_enter   = 1'b1;
          w_enter_b = 1'b1;
        end
      end
      StGntA: begin
        if (w_expired || !arb.req_a) begin
          if (arb.req_b) begin
            w_enter   = 1'b1;
            w_enter_b = 1'b1;
          end else if (arb.req_a) begin
            w_enter   = 1'b1;
            w_enter_b = 1'b0;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt + HoldOne;
        end
      end
      StGntB: begin
        if (w_expired || !arb.req_b) begin
          if (arb.req_a) begin
            w_enter   = 1'b1;
            w_enter_b = 1'b0;
          end else if (arb.req_b) begin
            w_enter   = 1'b1;
            w_enter_b = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt + HoldOne;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_enter) begin
      w_state_d = w_enter_b ? StGntB : StGntA;
      w_cnt_d   = '0;
      w_hold_d  = (arb.hold_len == '0) ? HoldOne : arb.hold_len;
      w_last_d  = w_enter_b;
      w_sel_d   = w_enter_b;
      // Re-grant of the current owner leaves sel alone, so no pulse.
      w_pulse_d = (w_enter_b != r_sel);
    end

    w_busy_d = (w_state_d != StIdle);
  end

  // State and registered outputs; reset leaves B as last served so A wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_hold  <= HoldOne;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_hold  <= w_hold_d;
      r_last  <= w_last_d;
      r_sel   <= w_sel_d;
      r_pulse <= w_pulse_d;
      r_busy  <= w_busy_d;
    end
  end

  assign arb.sel          = r_sel;
  assign arb.grant_a      = (r_state == StGntA);
  assign arb.grant_b      = (r_state == StGntB);
  assign arb.busy         = r_busy;
  assign arb.switch_pulse = r_pulse;

endmodule
